// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are byte addresses; fetch is word-granular.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode valid/ready channel carrying one instruction and its PC.
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with synchronous flush; head is shown combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    output logic         full,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    input  logic         flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; a flushed or reset queue hides it behind empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// PC register, ROM addressing and redirect arbitration in front of the fetch queue.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ROM_SIZE    = 64,
    parameter int ADDR_W      = $clog2(ROM_SIZE),
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    instruction_fetch_if.master        fetch_out
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Upper PC bits beyond the ROM simply alias by truncation.
    assign imem_addr = pc_q[ADDR_W+1:2];

    assign fetch_out.out_valid = !q_empty && !redirect_valid;
    assign fetch_out.out_instr = head.instr;
    assign fetch_out.out_pc    = head.pc;

    assign pop       = fetch_out.out_valid && fetch_out.out_ready;
    assign push      = !redirect_valid && (!q_full || pop);
    assign push_data = '{pc: pc_q, instr: imem_data};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (q_full),
        .pop       (pop),
        .head      (head),
        .empty     (q_empty),
        .flush     (redirect_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus predicts the delivered stream, a monitor checks it.
module tb_instruction_fetch;

    localparam int ROM_SIZE = 64;
    localparam int ADDR_W   = 6;
    localparam int DEPTH    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic [31:0]       rom [ROM_SIZE];

    instruction_fetch_if f_if ();

    instruction_fetch #(
        .ROM_SIZE    (ROM_SIZE),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_out      (f_if)
    );

    assign imem_data = rom[imem_addr];

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    exp_t        exp_q[$];
    logic [31:0] gen_pc = '0;
    bit          exp_valid = 1'b0;
    bit          prev_redirect = 1'b0;
    int          since = 0;

    // Delivered PCs form a consecutive run from the last restart point; ROM index wraps at 64 words.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{gen_pc, rom[int'((gen_pc >> 2) & 32'h3F)]});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        @(posedge clk);
        #1;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        f_if.out_ready  = rdy;
        if (prev_redirect) since = 0;
        else since++;
        if (rv) begin
            exp_q.delete();
            gen_pc = rpc & ~32'h3;
        end
        exp_valid     = !rv && (since >= 1);
        prev_redirect = rv;
        refill();
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        exp_valid      = 1'b0;
        exp_q.delete();
        gen_pc         = '0;
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        f_if.out_ready = 1'b1;
        since          = 0;
        prev_redirect  = 1'b0;
        exp_valid      = 1'b0;
        refill();
    endtask

    logic [ADDR_W-1:0] occ;
    exp_t              e;

    always @(negedge clk) begin
        if (rst) begin
            checks += 2;
            if (f_if.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid got %b want 0", f_if.out_valid);
            end
            if (imem_addr !== '0) begin
                errors++;
                $display("FAIL reset_addr got %0d want 0", imem_addr);
            end
        end else begin
            checks++;
            if (f_if.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL out_valid t=%0t got %b want %b", $time, f_if.out_valid, exp_valid);
            end
            if (f_if.out_valid === 1'b1) begin
                checks++;
                occ = imem_addr - f_if.out_pc[ADDR_W+1:2];
                if (occ < 1 || occ > DEPTH) begin
                    errors++;
                    $display("FAIL fetch_ahead t=%0t imem_addr %0d head_pc %h want 1..%0d words ahead",
                             $time, imem_addr, f_if.out_pc, DEPTH);
                end
                if (f_if.out_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_empty t=%0t got pc %h want no delivery", $time, f_if.out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        delivered++;
                        if (f_if.out_pc !== e.pc || f_if.out_instr !== e.instr) begin
                            errors++;
                            $display("FAIL deliver t=%0t got pc %h instr %h want pc %h instr %h",
                                     $time, f_if.out_pc, f_if.out_instr, e.pc, e.instr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 32'h1000_0000 + 32'(i);
        f_if.out_ready = 1'b0;

        // Streaming from reset.
        apply_reset(2);
        repeat (10) step(1'b0, '0, 1'b1);

        // Backpressure: queue fills and fetch address freezes.
        apply_reset(1);
        repeat (6) step(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (imem_addr !== 6'd2) begin
            errors++;
            $display("FAIL freeze_addr got %0d want 2", imem_addr);
        end
        repeat (6) step(1'b0, '0, 1'b1);

        // Single redirect in cycle 5.
        apply_reset(1);
        repeat (4) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0042, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);

        // Back-to-back redirects: last one wins.
        step(1'b1, 32'h0000_0020, 1'b1);
        step(1'b1, 32'h0000_0080, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);

        // ROM aliasing and 32-bit PC wrap.
        step(1'b1, 32'h0000_00FC, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1);

        // Redirect against a full queue with ready high.
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0010, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Reset mid-stream with a full queue.
        repeat (3) step(1'b0, '0, 1'b0);
        apply_reset(1);
        repeat (6) step(1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rv;
            bit          rdy;
            logic [31:0] tgt;
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            step(rv, tgt, rdy);
        end

        @(negedge clk);
        checks++;
        if (delivered < 150) begin
            errors++;
            $display("FAIL throughput got %0d deliveries want at least 150", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
